// File: rtl/io_pkg.sv
// Shared constants for the board input conditioning path.
package io_pkg;

  // 10 ms at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int SW_WIDTH_DEFAULT        = 16;
  // Short qualification window so simulations stay small.
  localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/io_input_conditioner_debounce.sv
// debounce_cell: 2-FF synchroniser, stability counter, rising-commit pulse.
// A change is accepted once the synchronised input has held one new value
// for CYCLES consecutive qualifying edges; any movement restarts the count.
module debounce_cell #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             rise
);

  localparam int             CW      = $clog2(CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CYCLES - 1);

  logic [WIDTH-1:0] s1_q,     s1_d;
  logic [WIDTH-1:0] s2_q,     s2_d;
  logic [WIDTH-1:0] s2_dly_q, s2_dly_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             rise_q,   rise_d;
  logic             commit;

  // Next state: synchroniser shift, qualification counter, commit.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    s2_dly_d = s2_q;
    stable_d = stable_q;
    count_d  = count_q;
    commit   = 1'b0;
    // Nothing pending, or input still moving (covers bounce between two
    // different non-stable vector values): restart qualification.
    if (s2_q == stable_q || s2_q != s2_dly_q) begin
      count_d = '0;
    end else if (count_q == CNT_MAX) begin
      commit   = 1'b1;
      stable_d = s2_q;
      count_d  = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
    // Only a 0->1 commit produces a pulse; releases just move the level.
    rise_d = commit & (|(s2_q & ~stable_q));
  end

  // State register; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s2_dly_q <= '0;
      stable_q <= '0;
      count_q  <= '0;
      rise_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s2_dly_q <= s2_dly_d;
      stable_q <= stable_d;
      count_q  <= count_d;
      rise_q   <= rise_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: debounces the two buttons and the switch bus for
// the memory-mapped IO unit. Buttons become single-cycle press pulses.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SW_WIDTH        = SW_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btnL_raw,
  input  logic                btnR_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic                buttonL,
  output logic                buttonR,
  output logic [SW_WIDTH-1:0] switch,
  output logic [1:0]          btn_level
);

  logic [1:0] btn_rise;
  logic       sw_rise_unused;

  // Buttons: index 0 = left, 1 = right; independent, may pulse together.
  debounce_cell #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_btn [1:0] (
    .clk    (clk),
    .reset  (reset),
    .raw    ({btnR_raw, btnL_raw}),
    .stable (btn_level),
    .rise   (btn_rise)
  );

  // Switch bus: level only, the pulse output has no consumer.
  debounce_cell #(.WIDTH(SW_WIDTH), .CYCLES(DEBOUNCE_CYCLES)) u_sw (
    .clk    (clk),
    .reset  (reset),
    .raw    (sw_raw),
    .stable (switch),
    .rise   (sw_rise_unused)
  );

  assign buttonL = btn_rise[0];
  assign buttonR = btn_rise[1];

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed scenarios plus random bouncing,
// every cycle compared against a sliding-window reference model.
module tb_io_input_conditioner;
  import io_pkg::*;

  localparam int D = DEBOUNCE_CYCLES_SIM;
  localparam int H = D + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btnL_raw = 1'b0, btnR_raw = 1'b0;
  logic [15:0] sw_raw = '0;
  logic        buttonL, buttonR;
  logic [15:0] switch;
  logic [1:0]  btn_level;

  io_input_conditioner #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .btnL_raw  (btnL_raw),
    .btnR_raw  (btnR_raw),
    .sw_raw    (sw_raw),
    .buttonL   (buttonL),
    .buttonR   (buttonR),
    .switch    (switch),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cnt_l = 0, cnt_r = 0;
  int both_seen = 0;
  int bad_sw = 0;

  // Model state: per cell (0=L, 1=R, 2=switch), raw samples taken at each
  // edge, newest first; the accepted value and the pulse.
  logic [15:0] hist [3][H];
  logic [15:0] st_m [3];
  logic        rise_m [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rule: an input commits value v at an edge when the D+1 samples
  // that have fully crossed the synchroniser (taken 2..D+2 edges ago) all
  // equal v and v differs from the accepted value. Reset empties history.
  task automatic model_edge();
    logic [15:0] cur [3];
    logic [15:0] v;
    logic        ok;
    cur[0] = {15'b0, btnL_raw};
    cur[1] = {15'b0, btnR_raw};
    cur[2] = sw_raw;
    for (int c = 0; c < 3; c++) begin
      if (!reset) begin
        for (int k = 0; k < H; k++) hist[c][k] = '0;
        st_m[c]   = '0;
        rise_m[c] = 1'b0;
      end else begin
        v  = hist[c][1];
        ok = (v != st_m[c]);
        for (int k = 1; k <= D + 1; k++) if (hist[c][k] != v) ok = 1'b0;
        rise_m[c] = ok && v[0] && !st_m[c][0];
        if (ok) st_m[c] = v;
        for (int k = H - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = cur[c];
      end
    end
  endtask

  task automatic step(input logic rst, input logic l, input logic r, input logic [15:0] s);
    @(negedge clk);
    reset = rst; btnL_raw = l; btnR_raw = r; sw_raw = s;
    if (!rst) begin
      #1;
      chk("async_reset", {12'b0, buttonR, buttonL, btn_level, switch}, 32'h0);
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("buttonL",   {31'b0, buttonL}, {31'b0, rise_m[0]});
    chk("buttonR",   {31'b0, buttonR}, {31'b0, rise_m[1]});
    chk("btn_level", {30'b0, btn_level}, {30'b0, st_m[1][0], st_m[0][0]});
    chk("switch",    {16'b0, switch}, {16'b0, st_m[2]});
    cnt_l += int'(buttonL);
    cnt_r += int'(buttonR);
    if (buttonL && buttonR) both_seen++;
    if (switch == 16'h00A5 || switch == 16'h005A) bad_sw++;
  endtask

  task automatic hold(input int n, input logic rst, input logic l, input logic r, input logic [15:0] s);
    for (int i = 0; i < n; i++) step(rst, l, r, s);
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < H; k++) hist[c][k] = '0;
      st_m[c] = '0; rise_m[c] = 1'b0;
    end

    // Reset held with every raw input high: outputs stay 0.
    hold(3, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    chk("rst_outputs", {12'b0, buttonR, buttonL, btn_level, switch}, 32'h0);
    cnt_l = 0; cnt_r = 0;
    hold(10, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    chk("rst_rel_pulseL", cnt_l, 1);
    chk("rst_rel_pulseR", cnt_r, 1);
    chk("rst_rel_switch", {16'b0, switch}, 32'hFFFF);

    // Everything back to 0: releases give no pulses.
    cnt_l = 0; cnt_r = 0;
    hold(10, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("release_no_pulse", cnt_l + cnt_r, 0);
    chk("release_level", {30'b0, btn_level}, 32'h0);

    // Clean press, long hold, release.
    cnt_l = 0;
    hold(106, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("hold_one_pulse", cnt_l, 1);
    chk("hold_level", {31'b0, btn_level[0]}, 32'h1);
    hold(10, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("hold_release_pulses", cnt_l, 1);
    chk("hold_release_level", {31'b0, btn_level[0]}, 32'h0);

    // Bouncing right button.
    cnt_r = 0;
    step(1'b1, 1'b0, 1'b1, 16'h0); step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b1, 16'h0); step(1'b1, 1'b0, 1'b0, 16'h0);
    hold(12, 1'b1, 1'b0, 1'b1, 16'h0);
    chk("bounce_one_pulse", cnt_r, 1);
    hold(8, 1'b1, 1'b0, 1'b0, 16'h0);

    // Switch glitches never reach the output.
    bad_sw = 0;
    hold(3, 1'b1, 1'b0, 1'b0, 16'h00A5);
    hold(3, 1'b1, 1'b0, 1'b0, 16'h005A);
    hold(10, 1'b1, 1'b0, 1'b0, 16'h1234);
    chk("sw_no_glitch", bad_sw, 0);
    chk("sw_final", {16'b0, switch}, 32'h1234);

    // Simultaneous press.
    both_seen = 0;
    hold(10, 1'b1, 1'b1, 1'b1, 16'h1234);
    chk("simultaneous", both_seen, 1);
    hold(8, 1'b1, 1'b0, 1'b0, 16'h1234);

    // Reset two cycles into qualification of a press.
    cnt_l = 0;
    hold(2, 1'b1, 1'b1, 1'b0, 16'h1234);
    hold(1, 1'b0, 1'b1, 1'b0, 16'h1234);
    hold(5, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("midrst_no_early", cnt_l, 0);
    hold(6, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("midrst_one_pulse", cnt_l, 1);

    // Random bouncing inputs with occasional reset.
    begin
      logic l, r, rs;
      logic [15:0] s;
      l = 1'b1; r = 1'b0; s = 16'h0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(7) == 0) l = ~l;
        if ($urandom_range(9) == 0) r = ~r;
        if ($urandom_range(11) == 0) s = 16'($urandom);
        rs = ($urandom_range(299) != 0);
        step(rs, l, r, s);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
